// File: rtl/dec_stage.sv
`default_nettype none
// ============================================================================
// Module   : dec_stage
// Purpose  : Decode stage with a 32x32 register file, two combinational read
//            ports, one write-back port and an opcode-driven immediate extender.
// Revision : 1.0
// ============================================================================
module dec_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        RF_WrEn,
    input  logic        RF_WrData_sel,
    input  logic        RF_B_sel,
    input  logic [31:0] ALU_out,
    input  logic [31:0] MEM_out,
    output logic [31:0] RF_A,
    output logic [31:0] RF_B,
    output logic [31:0] Immed
);

    localparam logic [5:0] c_OP_ANDI = 6'b110010;
    localparam logic [5:0] c_OP_ORI  = 6'b110011;
    localparam logic [5:0] c_OP_LUI  = 6'b111001;
    localparam logic [5:0] c_OP_B    = 6'b111111;
    localparam logic [5:0] c_OP_BEQ  = 6'b010000;
    localparam logic [5:0] c_OP_BNE  = 6'b010001;

    logic [31:0] rf_q [0:31];

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rd;
    logic [4:0]  w_rt;
    logic [15:0] w_imm;
    logic [4:0]  w_b_addr;
    logic [31:0] w_wr_data;
    logic [31:0] w_sext;

    assign w_opcode  = Instr[31:26];
    assign w_rs      = Instr[25:21];
    assign w_rd      = Instr[20:16];
    assign w_rt      = Instr[15:11];
    assign w_imm     = Instr[15:0];
    assign w_b_addr  = RF_B_sel ? w_rd : w_rt;
    assign w_wr_data = RF_WrData_sel ? MEM_out : ALU_out;
    assign w_sext    = {{16{w_imm[15]}}, w_imm};

    // Reset wins over a same-edge write; R0 is never written.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (RF_WrEn && (w_rd != 5'd0)) begin
            rf_q[w_rd] <= w_wr_data;
        end
    end

    // R0 is forced to zero on read so it is defined even before the first reset.
    assign RF_A = (w_rs     == 5'd0) ? 32'h0 : rf_q[w_rs];
    assign RF_B = (w_b_addr == 5'd0) ? 32'h0 : rf_q[w_b_addr];

    always_comb begin
        Immed = w_sext;
        case (w_opcode)
            c_OP_ANDI, c_OP_ORI:        Immed = {16'h0000, w_imm};
            c_OP_LUI:                   Immed = {w_imm, 16'h0000};
            c_OP_B, c_OP_BEQ, c_OP_BNE: Immed = {w_sext[29:0], 2'b00};
            default:                    Immed = w_sext;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_stage
// Purpose  : Randomized self-checking bench for dec_stage against an
//            array-based register model and arithmetic immediate model.
// Revision : 1.0
// ============================================================================
module tb_dec_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Instr;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic [31:0] ALU_out;
    logic [31:0] MEM_out;
    logic [31:0] RF_A;
    logic [31:0] RF_B;
    logic [31:0] Immed;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [32];

    dec_stage u_dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Instr        (Instr),
        .RF_WrEn      (RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel),
        .RF_B_sel     (RF_B_sel),
        .ALU_out      (ALU_out),
        .MEM_out      (MEM_out),
        .RF_A         (RF_A),
        .RF_B         (RF_B),
        .Immed        (Immed)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs, rd, imm};
    endfunction

    function automatic logic [31:0] imm_ref(input logic [5:0] op, input logic [15:0] imm);
        int s;
        s = (int'(imm) >= 32768) ? int'(imm) - 65536 : int'(imm);
        case (op)
            6'b110010, 6'b110011:            return 32'(int'(imm));
            6'b111001:                       return 32'(int'(imm)) << 16;
            6'b111111, 6'b010000, 6'b010001: return 32'(s * 4);
            default:                         return 32'(s);
        endcase
    endfunction

    // Apply this cycle's inputs to the model, then cross the edge.
    task automatic tick();
        if (Reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (RF_WrEn && Instr[20:16] != 5'd0) begin
            model[Instr[20:16]] = RF_WrData_sel ? MEM_out : ALU_out;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset = 1'b0; RF_WrEn = 1'b0; RF_WrData_sel = 1'b0; RF_B_sel = 1'b0;
        ALU_out = 32'h0; MEM_out = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        idle();
        Instr = mk(6'b100000, 5'd0, rd, 16'h0);
        RF_WrEn = 1'b1; ALU_out = val;
        tick();
        RF_WrEn = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1; RF_WrEn = 1'b1; ALU_out = 32'hFFFF_FFFF;
        Instr = mk(6'b100000, 5'd0, 5'd7, 16'h0);
        tick();
        tick();
        idle();
        for (int a = 0; a < 32; a++) begin
            Instr = mk(6'b100000, 5'(a), 5'd0, {5'(a), 11'h0});
            #1;
            total++;
            if (RF_A !== 32'h0) begin
                bad++; $display("FAIL reset_rfa[%0d] got=%h exp=00000000", a, RF_A);
            end
            total++;
            if (RF_B !== 32'h0) begin
                bad++; $display("FAIL reset_rfb[%0d] got=%h exp=00000000", a, RF_B);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        Instr = mk(6'b100000, 5'd5, 5'd5, 16'h0);
        RF_WrEn = 1'b1; ALU_out = 32'hDEAD_BEEF; MEM_out = 32'h1111_1111;
        #1;
        total++;
        if (RF_A !== 32'h0) begin
            bad++; $display("FAIL same_cycle_old got=%h exp=00000000", RF_A);
        end
        tick();
        RF_WrEn = 1'b0;
        #1;
        total++;
        if (RF_A !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL write_r5 got=%h exp=deadbeef", RF_A);
        end
    endtask

    task automatic test_r0_r31();
        logic [31:0] r30_exp;
        idle();
        Instr = mk(6'b100000, 5'd0, 5'd0, 16'h0);
        RF_WrEn = 1'b1; RF_WrData_sel = 1'b1; MEM_out = 32'h1234_5678; RF_B_sel = 1'b1;
        tick();
        RF_WrEn = 1'b0;
        #1;
        total++;
        if (RF_A !== 32'h0) begin
            bad++; $display("FAIL r0_rfa got=%h exp=00000000", RF_A);
        end
        total++;
        if (RF_B !== 32'h0) begin
            bad++; $display("FAIL r0_rfb got=%h exp=00000000", RF_B);
        end
        write_reg(5'd30, 32'hA5A5_0030);
        r30_exp = model[30];
        write_reg(5'd31, 32'h3131_3131);
        Instr = mk(6'b100000, 5'd31, 5'd0, {5'd30, 11'h0});
        #1;
        total++;
        if (RF_A !== 32'h3131_3131) begin
            bad++; $display("FAIL r31_write got=%h exp=31313131", RF_A);
        end
        total++;
        if (RF_B !== r30_exp) begin
            bad++; $display("FAIL r30_untouched got=%h exp=%h", RF_B, r30_exp);
        end
    endtask

    task automatic test_bsel();
        write_reg(5'd3, 32'd7);
        write_reg(5'd4, 32'd9);
        Instr = mk(6'b100000, 5'd3, 5'd3, {5'd4, 11'h0});
        RF_B_sel = 1'b0;
        #1;
        total++;
        if (RF_B !== 32'd9) begin
            bad++; $display("FAIL bsel0 got=%h exp=00000009", RF_B);
        end
        RF_B_sel = 1'b1;
        #1;
        total++;
        if (RF_B !== 32'd7) begin
            bad++; $display("FAIL bsel1 got=%h exp=00000007", RF_B);
        end
        total++;
        if (RF_A !== RF_B) begin
            bad++; $display("FAIL same_reg_ports got=%h exp=%h", RF_A, RF_B);
        end
    endtask

    task automatic test_immed();
        logic [5:0]  ops  [5] = '{6'b110000, 6'b110011, 6'b111001, 6'b010000, 6'b100000};
        logic [31:0] exps [5] = '{32'hFFFF_8004, 32'h0000_8004, 32'h8004_0000,
                                  32'hFFFE_0010, 32'hFFFF_8004};
        idle();
        for (int i = 0; i < 5; i++) begin
            Instr = mk(ops[i], 5'd0, 5'd0, 16'h8004);
            #1;
            total++;
            if (Immed !== exps[i]) begin
                bad++; $display("FAIL immed_8004 op=%b got=%h exp=%h", ops[i], Immed, exps[i]);
            end
        end
        for (int op = 0; op < 64; op++) begin
            logic [15:0] imm;
            imm = 16'($urandom);
            Instr = mk(6'(op), 5'($urandom), 5'($urandom), imm);
            #1;
            total++;
            if (Immed !== imm_ref(6'(op), imm)) begin
                bad++; $display("FAIL immed_op op=%b imm=%h got=%h exp=%h",
                                6'(op), imm, Immed, imm_ref(6'(op), imm));
            end
        end
    endtask

    task automatic test_reset_priority();
        idle();
        write_reg(5'd6, 32'h0000_0666);
        Reset = 1'b1; RF_WrEn = 1'b1; ALU_out = 32'h0000_0123;
        Instr = mk(6'b100000, 5'd6, 5'd6, 16'h0);
        tick();
        idle();
        #1;
        total++;
        if (RF_A !== 32'h0) begin
            bad++; $display("FAIL reset_prio_r6 got=%h exp=00000000", RF_A);
        end
        write_reg(5'd6, 32'd5);
        Instr = mk(6'b100000, 5'd6, 5'd0, 16'h0);
        #1;
        total++;
        if (RF_A !== 32'd5) begin
            bad++; $display("FAIL after_reset_r6 got=%h exp=00000005", RF_A);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ea, eb;
            logic [4:0]  baddr;
            Instr         = $urandom;
            Reset         = ($urandom_range(0, 49) == 0);
            RF_WrEn       = 1'($urandom);
            RF_WrData_sel = 1'($urandom);
            RF_B_sel      = 1'($urandom);
            ALU_out       = $urandom;
            MEM_out       = $urandom;
            #1;
            baddr = RF_B_sel ? Instr[20:16] : Instr[15:11];
            ea = model[Instr[25:21]];
            eb = model[baddr];
            total++;
            if (RF_A !== ea) begin
                bad++; $display("FAIL rand_rfa n=%0d got=%h exp=%h", n, RF_A, ea);
            end
            total++;
            if (RF_B !== eb) begin
                bad++; $display("FAIL rand_rfb n=%0d got=%h exp=%h", n, RF_B, eb);
            end
            total++;
            if (Immed !== imm_ref(Instr[31:26], Instr[15:0])) begin
                bad++; $display("FAIL rand_immed n=%0d got=%h exp=%h", n, Immed,
                                imm_ref(Instr[31:26], Instr[15:0]));
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        idle();
        Instr = 32'h0;
        @(posedge Clk);
        #1;
        test_reset();
        test_write_read();
        test_r0_r31();
        test_bsel();
        test_immed();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
